// File: rtl/pushbutton_conditioner.sv
// rtl/pushbutton_conditioner.sv - push-button synchroniser, debouncer and press/release/long-press event generator (optional PUSHBUTTON_LONGPRESS_EN)
module pushbutton_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 4,
    parameter int LONG_PRESS_CYCLES = 16
) (
    input  logic clock,
    input  logic resetN,
    input  logic pushButton,
    output logic buttonLevel,
    output logic pressPulse,
    output logic releasePulse,
    output logic longPressPulse
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        RELEASED      = 2'd0,
        CHECK_PRESS   = 2'd1,
        PRESSED       = 2'd2,
        CHECK_RELEASE = 2'd3
    } state_t;

    // Both counts must be at least one for the counters to make sense.
    if (DEBOUNCE_CYCLES < 1 || LONG_PRESS_CYCLES < 1) begin : g_bad_param
        $error("pushbutton_conditioner: DEBOUNCE_CYCLES and LONG_PRESS_CYCLES must be >= 1");
    end

    logic          sync1_q, sync2_q;
    state_t        state_q, state_d;
    logic [DW-1:0] db_q, db_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;

    // Two-flop synchroniser for the asynchronous button pin.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pushButton;
            sync2_q <= sync1_q;
        end
    end

    // Debounce FSM next state; a transition is accepted on the DEBOUNCE_CYCLES-th consecutive sample.
    always_comb begin
        state_d   = state_q;
        db_d      = db_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            RELEASED: begin
                if (sync2_q) begin
                    if (DB_LAST == DW'(1)) begin
                        state_d = PRESSED;
                        press_d = 1'b1;
                        db_d    = '0;
                    end else begin
                        state_d = CHECK_PRESS;
                        db_d    = DW'(1);
                    end
                end
            end
            CHECK_PRESS: begin
                if (!sync2_q) begin
                    state_d = RELEASED;
                    db_d    = '0;
                end else if (db_q == DB_LAST - DW'(1)) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                    db_d    = '0;
                end else begin
                    db_d = db_q + DW'(1);
                end
            end
            PRESSED: begin
                if (!sync2_q) begin
                    if (DB_LAST == DW'(1)) begin
                        state_d   = RELEASED;
                        release_d = 1'b1;
                        db_d      = '0;
                    end else begin
                        state_d = CHECK_RELEASE;
                        db_d    = DW'(1);
                    end
                end
            end
            CHECK_RELEASE: begin
                if (sync2_q) begin
                    state_d = PRESSED;
                    db_d    = '0;
                end else if (db_q == DB_LAST - DW'(1)) begin
                    state_d   = RELEASED;
                    release_d = 1'b1;
                    db_d      = '0;
                end else begin
                    db_d = db_q + DW'(1);
                end
            end
            default: begin
                state_d = RELEASED;
                db_d    = '0;
            end
        endcase
        level_d = (state_d == PRESSED) || (state_d == CHECK_RELEASE);
    end

    // FSM state and registered outputs; level and pulses change on the same edge.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_q   <= RELEASED;
            db_q      <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            db_q      <= db_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign buttonLevel  = level_q;
    assign pressPulse   = press_q;
    assign releasePulse = release_q;

`ifdef PUSHBUTTON_LONGPRESS_EN
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES);

    logic [HW-1:0] hold_q, hold_d;
    logic          long_q, long_d;
    logic          entering_pressed;
    logic          holding;

    assign entering_pressed = (state_d == PRESSED) &&
                              ((state_q == RELEASED) || (state_q == CHECK_PRESS));
    assign holding          = (state_q == PRESSED) || (state_q == CHECK_RELEASE);

    // Saturating hold counter; release acceptance wins over a same-edge long-press event.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (state_d == RELEASED || entering_pressed) begin
            hold_d = '0;
        end else if (holding && hold_q != HOLD_MAX) begin
            hold_d = hold_q + HW'(1);
            long_d = (hold_q == HOLD_MAX - HW'(1));
        end
    end

    // Hold counter and long-press pulse registers.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign longPressPulse = long_q;
`else
    assign longPressPulse = 1'b0;
`endif

endmodule

// File: tb/tb_pushbutton_conditioner.sv
// tb/tb_pushbutton_conditioner.sv - scoreboard bench for pushbutton_conditioner
module tb_pushbutton_conditioner;

    logic clock = 1'b0;
    logic resetN = 1'b0;
    logic pushButton = 1'b0;
    logic buttonLevel, pressPulse, releasePulse, longPressPulse;

    pushbutton_conditioner #(.DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(16)) dut (
        .clock(clock),
        .resetN(resetN),
        .pushButton(pushButton),
        .buttonLevel(buttonLevel),
        .pressPulse(pressPulse),
        .releasePulse(releasePulse),
        .longPressPulse(longPressPulse)
    );

    always #5 clock = ~clock;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    int  cyc = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    ev_t exp_q[$];
    ev_t obs_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    // Event monitor: records every pulse with the edge count it followed.
    always @(negedge clock) begin
        ev_t e;
        if (pressPulse === 1'b1) begin e.kind = 0; e.cyc = cyc; obs_q.push_back(e); end
        if (releasePulse === 1'b1) begin e.kind = 1; e.cyc = cyc; obs_q.push_back(e); end
        if (longPressPulse === 1'b1) begin e.kind = 2; e.cyc = cyc; obs_q.push_back(e); end
        if (resetN === 1'b1) begin
            n_cmp++;
            if ((pressPulse & releasePulse) !== 1'b0) begin
                n_bad++;
                $display("FAIL exclusive_pulses: cycle %0d press=%b release=%b required not both 1",
                         cyc, pressPulse, releasePulse);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick(1);
    endtask

    task automatic expect_ev(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic check_level(input string name, input logic want);
        n_cmp++;
        if (buttonLevel !== want) begin
            n_bad++;
            $display("FAIL %s: cycle %0d buttonLevel=%b required %b", name, cyc, buttonLevel, want);
        end
    endtask

    task automatic check_sb(input string name);
        ev_t e, o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++;
                $display("FAIL %s: no event seen, required kind %0d at cycle %0d", name, e.kind, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.cyc !== e.cyc) begin
                    n_bad++;
                    $display("FAIL %s: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                             name, o.kind, o.cyc, e.kind, e.cyc);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s: %0d unexpected event(s), first kind %0d at cycle %0d, required none",
                     name, obs_q.size(), obs_q[0].kind, obs_q[0].cyc);
        end
        obs_q.delete();
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        pushButton = 1'b0;
        tick(3);
        resetN = 1'b1;
        obs_q.delete();
        for (int i = 0; i < 20; i++) begin
            tick(1);
            n_cmp++;
            if ({buttonLevel, pressPulse, releasePulse, longPressPulse} !== 4'b0000) begin
                n_bad++;
                $display("FAIL reset_idle: cycle %0d outputs=%b%b%b%b required 0000", cyc,
                         buttonLevel, pressPulse, releasePulse, longPressPulse);
            end
        end
        check_sb("reset_events");
    endtask

    task automatic test_glitch(input int width);
        tick(1);
        pushButton = 1'b1;
        tick(width);
        pushButton = 1'b0;
        tick(12);
        check_level($sformatf("glitch%0d_level", width), 1'b0);
        check_sb($sformatf("glitch%0d_events", width));
    endtask

    task automatic test_press();
        int c;
        tick(1);
        pushButton = 1'b1;
        c = cyc;
        expect_ev(0, c + 6);
        wait_until(c + 5);
        check_level("press_before_latency", 1'b0);
        wait_until(c + 6);
        check_level("press_at_latency", 1'b1);
        wait_until(c + 8);
        check_sb("press_events");
    endtask

    task automatic test_release_bounce();
        int c;
        pushButton = 1'b0;
        tick(1);
        pushButton = 1'b1;
        tick(1);
        pushButton = 1'b0;
        c = cyc;
        expect_ev(1, c + 6);
        wait_until(c + 5);
        check_level("release_before_latency", 1'b1);
        wait_until(c + 6);
        check_level("release_at_latency", 1'b0);
        wait_until(c + 10);
        check_sb("release_bounce_events");
    endtask

    task automatic test_long_press();
        int p, r;
        tick(1);
        pushButton = 1'b1;
        p = cyc + 6;
        expect_ev(0, p);
`ifdef PUSHBUTTON_LONGPRESS_EN
        expect_ev(2, p + 16);
`endif
        wait_until(p + 30);
        pushButton = 1'b0;
        r = cyc;
        expect_ev(1, r + 6);
        wait_until(r + 10);
        check_sb("long_hold_events");

        tick(1);
        pushButton = 1'b1;
        p = cyc + 6;
        expect_ev(0, p);
        wait_until(p + 4);
        pushButton = 1'b0;
        r = cyc;
        expect_ev(1, r + 6);
        wait_until(r + 20);
        check_sb("short_hold_events");
    endtask

    task automatic test_reset_mid_debounce();
        int c, cr;
        tick(1);
        pushButton = 1'b1;
        c = cyc;
        wait_until(c + 4);
        resetN = 1'b0;
        tick(1);
        check_level("reset_mid_check_level", 1'b0);
        tick(1);
        resetN = 1'b1;
        cr = cyc;
        expect_ev(0, cr + 6);
        wait_until(cr + 5);
        check_level("reset_held_before_latency", 1'b0);
        wait_until(cr + 6);
        check_level("reset_held_at_latency", 1'b1);
        wait_until(cr + 8);
        resetN = 1'b0;
        tick(1);
        check_level("reset_in_pressed_level", 1'b0);
        pushButton = 1'b0;
        tick(1);
        resetN = 1'b1;
        tick(12);
        check_level("reset_after_release_level", 1'b0);
        check_sb("reset_mid_events");
    endtask

    initial begin
        fork
            begin
                #200000;
                $display("FAIL watchdog: time limit reached at cycle %0d, required completion", cyc);
                $fatal(1, "watchdog");
            end
        join_none
        test_reset();
        test_glitch(2);
        test_glitch(3);
        test_press();
        test_release_bounce();
        test_long_press();
        test_reset_mid_debounce();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
